// File: rtl/change56_to_64_pkg.sv
// Shared definitions for the 56/64-bit width converters on the packing path.
package change56_to_64_pkg;

    localparam int IN_W      = 56;
    localparam int OUT_W     = 64;
    localparam int GROUP_IN  = 8;
    localparam int GROUP_OUT = 7;

    // Number of residual bits carried in temp after cnt input words of a group.
    // An empty group (cnt==0) carries nothing; otherwise 64-8*cnt bits remain.
    function automatic logic [6:0] residual_bits(input logic [2:0] cnt);
        if (cnt == 3'd0) begin
            return 7'd0;
        end else begin
            return 7'd64 - {1'b0, cnt, 3'b000};
        end
    endfunction

endpackage

// File: rtl/change56_to_64.sv
// Packs a stream of 56-bit words into 64-bit words, MSB-first.
// Eight input words form a group that yields seven output words; a flush
// closes a partial group with a left-aligned, padded final word.
module change56_to_64
    import change56_to_64_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inflag,
    input  logic [IN_W-1:0]   Din,
    input  logic              flush,
    output logic [OUT_W-1:0]  Dout,
    output logic              D_flag,
    output logic              last
);

    // Group state: words accepted so far and right-aligned leftover bits.
    logic [2:0]        cnt_r;
    logic [IN_W-1:0]   temp_r;

    // Next-state values feeding the single register stage.
    logic [2:0]        cnt_nxt_s;
    logic [IN_W-1:0]   temp_nxt_s;
    logic [OUT_W-1:0]  dout_nxt_s;
    logic              dflag_nxt_s;
    logic              last_nxt_s;

    // Flush word construction helpers.
    logic [6:0]        resid_s;
    logic [6:0]        pad_shift_s;
    logic [OUT_W-1:0]  pad_mask_s;
    logic [OUT_W-1:0]  temp_ext_s;
    logic [OUT_W-1:0]  flush_word_s;

    // Left-align the residual bits and fill the low-order remainder with PAD_BYTE.
    always_comb begin
        resid_s      = residual_bits(cnt_r);
        pad_shift_s  = 7'd64 - resid_s;
        pad_mask_s   = (64'd1 << pad_shift_s) - 64'd1;
        temp_ext_s   = {8'd0, temp_r};
        flush_word_s = (temp_ext_s << pad_shift_s) | ({8{PAD_BYTE}} & pad_mask_s);
    end

    // Next-state and output selection; inflag has priority over flush.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        temp_nxt_s  = temp_r;
        dout_nxt_s  = 64'd0;
        dflag_nxt_s = 1'b0;
        last_nxt_s  = 1'b0;
        if (inflag) begin
            cnt_nxt_s = cnt_r + 3'd1;
            case (cnt_r)
                3'd0: begin
                    // First word of a group only fills the residual register.
                    temp_nxt_s = Din;
                end
                3'd1: begin
                    dout_nxt_s  = {temp_r[55:0], Din[55:48]};
                    temp_nxt_s  = {8'd0, Din[47:0]};
                    dflag_nxt_s = 1'b1;
                end
                3'd2: begin
                    dout_nxt_s  = {temp_r[47:0], Din[55:40]};
                    temp_nxt_s  = {16'd0, Din[39:0]};
                    dflag_nxt_s = 1'b1;
                end
                3'd3: begin
                    dout_nxt_s  = {temp_r[39:0], Din[55:32]};
                    temp_nxt_s  = {24'd0, Din[31:0]};
                    dflag_nxt_s = 1'b1;
                end
                3'd4: begin
                    dout_nxt_s  = {temp_r[31:0], Din[55:24]};
                    temp_nxt_s  = {32'd0, Din[23:0]};
                    dflag_nxt_s = 1'b1;
                end
                3'd5: begin
                    dout_nxt_s  = {temp_r[23:0], Din[55:16]};
                    temp_nxt_s  = {40'd0, Din[15:0]};
                    dflag_nxt_s = 1'b1;
                end
                3'd6: begin
                    dout_nxt_s  = {temp_r[15:0], Din[55:8]};
                    temp_nxt_s  = {48'd0, Din[7:0]};
                    dflag_nxt_s = 1'b1;
                end
                3'd7: begin
                    // Eighth word completes the group exactly; nothing is left over.
                    dout_nxt_s  = {temp_r[7:0], Din[55:0]};
                    temp_nxt_s  = 56'd0;
                    dflag_nxt_s = 1'b1;
                    last_nxt_s  = 1'b1;
                end
                default: begin
                    cnt_nxt_s  = 3'd0;
                    temp_nxt_s = 56'd0;
                end
            endcase
        end else if (flush) begin
            if (cnt_r != 3'd0) begin
                dout_nxt_s  = flush_word_s;
                dflag_nxt_s = 1'b1;
                last_nxt_s  = 1'b1;
                cnt_nxt_s   = 3'd0;
                temp_nxt_s  = 56'd0;
            end else begin
                // Empty group: a flush has nothing to emit.
                cnt_nxt_s  = cnt_r;
                temp_nxt_s = temp_r;
            end
        end else begin
            // Idle: hold group state, outputs return to zero.
            cnt_nxt_s  = cnt_r;
            temp_nxt_s = temp_r;
        end
    end

    // Register group state and outputs; reset discards any partial group.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r  <= 3'd0;
            temp_r <= 56'd0;
            Dout   <= 64'd0;
            D_flag <= 1'b0;
            last   <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            temp_r <= temp_nxt_s;
            Dout   <= dout_nxt_s;
            D_flag <= dflag_nxt_s;
            last   <= last_nxt_s;
        end
    end

endmodule

// File: tb/tb_change56_to_64.sv
// Directed bench for change56_to_64: ramp groups, back-to-back groups,
// flush handling, asynchronous reset and a 56->64->56 round trip.
module tb_change56_to_64;

    logic        clk;
    logic        rst;
    logic        inflag;
    logic [55:0] din;
    logic        flush;
    logic [63:0] dout;
    logic        d_flag;
    logic        last;

    int total;
    int bad;

    change56_to_64 #(.PAD_BYTE(8'h00)) dut (
        .clk    (clk),
        .rst    (rst),
        .inflag (inflag),
        .Din    (din),
        .flush  (flush),
        .Dout   (dout),
        .D_flag (d_flag),
        .last   (last)
    );

    // 10 ns clock, rising edge active.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ramp input word i: bytes 7i .. 7i+6, first byte in the top bits.
    function automatic logic [55:0] ramp_in(input int i);
        logic [55:0] w;
        w = 56'd0;
        for (int b = 0; b < 7; b++) w = {w[47:0], 8'(7 * i + b)};
        return w;
    endfunction

    // Ramp output word j: bytes 8j .. 8j+7 of the same byte stream.
    function automatic logic [63:0] ramp_out(input int j);
        logic [63:0] w;
        w = 64'd0;
        for (int b = 0; b < 8; b++) w = {w[55:0], 8'(8 * j + b)};
        return w;
    endfunction

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic cycle(input logic [55:0] d, input logic v, input logic f);
        din    = d;
        inflag = v;
        flush  = f;
        @(posedge clk);
        #1;
    endtask

    // Feed one ramp group and check all eight output slots.
    task automatic ramp_group(input string tag);
        for (int k = 0; k < 8; k++) begin
            cycle(ramp_in(k), 1'b1, 1'b0);
            total++;
            if (d_flag !== (k != 0)) begin
                bad++;
                $display("FAIL %s_flag k=%0d got=%b exp=%b", tag, k, d_flag, (k != 0));
            end
            if (k != 0) begin
                total++;
                if (dout !== ramp_out(k - 1) || last !== (k == 7)) begin
                    bad++;
                    $display("FAIL %s_word k=%0d got=%h/%b exp=%h/%b", tag, k, dout, last,
                             ramp_out(k - 1), (k == 7));
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; inflag = 1'b0; flush = 1'b0; din = 56'd0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (dout !== 64'd0 || d_flag !== 1'b0 || last !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%h/%b/%b exp=0/0/0", dout, d_flag, last);
        end
        rst = 1'b1;
        cycle(56'd0, 1'b0, 1'b0);
    endtask

    task automatic test_ramp();
        ramp_group("ramp");
        cycle(56'd0, 1'b0, 1'b0);
        total++;
        if (d_flag !== 1'b0 || dout !== 64'd0) begin
            bad++;
            $display("FAIL ramp_idle got=%h/%b exp=0/0", dout, d_flag);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 16; k++) begin
            cycle(ramp_in(k % 8), 1'b1, 1'b0);
            total++;
            if (d_flag !== ((k % 8) != 0)) begin
                bad++;
                $display("FAIL b2b_flag k=%0d got=%b exp=%b", k, d_flag, ((k % 8) != 0));
            end
            if ((k % 8) != 0) begin
                total++;
                if (dout !== ramp_out((k % 8) - 1) || last !== ((k % 8) == 7)) begin
                    bad++;
                    $display("FAIL b2b_word k=%0d got=%h/%b exp=%h/%b", k, dout, last,
                             ramp_out((k % 8) - 1), ((k % 8) == 7));
                end
            end
        end
        cycle(56'd0, 1'b0, 1'b0);
    endtask

    task automatic test_flush_partial();
        cycle(ramp_in(0), 1'b1, 1'b0);
        cycle(ramp_in(1), 1'b1, 1'b0);
        total++;
        if (d_flag !== 1'b1 || dout !== 64'h0001020304050607 || last !== 1'b0) begin
            bad++;
            $display("FAIL flush_first got=%h/%b/%b exp=0001020304050607/1/0", dout, d_flag, last);
        end
        cycle(56'd0, 1'b0, 1'b1);
        total++;
        if (d_flag !== 1'b1 || dout !== 64'h08090A0B0C0D0000 || last !== 1'b1) begin
            bad++;
            $display("FAIL flush_pad got=%h/%b/%b exp=08090a0b0c0d0000/1/1", dout, d_flag, last);
        end
        cycle(56'd0, 1'b0, 1'b0);
        ramp_group("after_flush");
        cycle(56'd0, 1'b0, 1'b0);
    endtask

    task automatic test_flush_corner();
        // Group just completed, so cnt is 0: flush must stay silent.
        cycle(56'd0, 1'b0, 1'b1);
        total++;
        if (d_flag !== 1'b0 || last !== 1'b0 || dout !== 64'd0) begin
            bad++;
            $display("FAIL flush_cnt0 got=%h/%b/%b exp=0/0/0", dout, d_flag, last);
        end
        cycle(ramp_in(0), 1'b1, 1'b1);
        total++;
        if (d_flag !== 1'b0 || last !== 1'b0) begin
            bad++;
            $display("FAIL flush_with_in got=%b/%b exp=0/0", d_flag, last);
        end
        // Flush held for the next cycle closes the one-word group.
        cycle(56'd0, 1'b0, 1'b1);
        total++;
        if (d_flag !== 1'b1 || last !== 1'b1 || dout !== 64'h0001020304050600) begin
            bad++;
            $display("FAIL flush_held got=%h/%b/%b exp=0001020304050600/1/1", dout, d_flag, last);
        end
        cycle(56'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        cycle(ramp_in(0), 1'b1, 1'b0);
        cycle(ramp_in(1), 1'b1, 1'b0);
        cycle(ramp_in(2), 1'b1, 1'b0);
        inflag = 1'b0;
        rst    = 1'b0;
        #2;
        total++;
        if (dout !== 64'd0 || d_flag !== 1'b0 || last !== 1'b0) begin
            bad++;
            $display("FAIL reset_async got=%h/%b/%b exp=0/0/0", dout, d_flag, last);
        end
        #1;
        rst = 1'b1;
        ramp_group("post_reset");
        cycle(56'd0, 1'b0, 1'b0);
    endtask

    task automatic test_round_trip();
        logic [55:0]  words [16];
        logic [63:0]  outq[$];
        logic [447:0] v;
        for (int i = 0; i < 16; i++) words[i] = {$urandom, $urandom} & 56'hFFFFFFFFFFFFFF;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) cycle(words[i], 1'b1, 1'b0);
            else        cycle(56'd0, 1'b0, 1'b0);
            if (d_flag === 1'b1) outq.push_back(dout);
        end
        total++;
        if (outq.size() != 14) begin
            bad++;
            $display("FAIL rt_count got=%0d exp=14", outq.size());
        end else begin
            for (int g = 0; g < 2; g++) begin
                v = 448'd0;
                for (int j = 0; j < 7; j++) v = {v[383:0], outq[7 * g + j]};
                for (int i = 0; i < 8; i++) begin
                    total++;
                    if (v[447 - 56 * i -: 56] !== words[8 * g + i]) begin
                        bad++;
                        $display("FAIL rt_word g=%0d i=%0d got=%h exp=%h", g, i,
                                 v[447 - 56 * i -: 56], words[8 * g + i]);
                    end
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_ramp();
        test_back_to_back();
        test_flush_partial();
        test_flush_corner();
        test_reset_mid();
        test_round_trip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
